// File: rtl/scene_pkg.sv
// Shared scene layout and commit-controller state encoding for the
// frontend / commit controller / rasteriser boundary.
package scene_pkg;

  localparam int SCENE_W = 105;

  // Field offsets into the packed scene word (LSB, MSB inclusive).
  localparam int BG_LSB         = 0;
  localparam int BG_MSB         = 5;
  localparam int POLY_COLOR_LSB = 6;
  localparam int POLY_COLOR_MSB = 17;
  localparam int V0_X_LSB       = 18;
  localparam int V0_X_MSB       = 31;
  localparam int V0_Y_LSB       = 32;
  localparam int V0_Y_MSB       = 43;
  localparam int V1_X_LSB       = 44;
  localparam int V1_X_MSB       = 57;
  localparam int V1_Y_LSB       = 58;
  localparam int V1_Y_MSB       = 69;
  localparam int V2_X_LSB       = 70;
  localparam int V2_X_MSB       = 83;
  localparam int V2_Y_LSB       = 84;
  localparam int V2_Y_MSB       = 95;
  localparam int DEPTH_LSB      = 96;
  localparam int DEPTH_MSB      = 101;
  localparam int POLY_EN_LSB    = 102;
  localparam int POLY_EN_MSB    = 103;
  localparam int EN_SCREEN      = 104;

  typedef enum logic {
    ARMED = 1'b0,
    DEFER = 1'b1
  } commit_state_e;

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchroniser for a single asynchronous level; the reset value
// lets the output come up in the signal's idle level.
module cdc_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/scene_commit_ctrl.sv
// Frame-synchronous scene commit: swaps the active scene at the start of
// vblank, defers while SPI is busy, and schedules the SPI load window.
module scene_commit_ctrl
  import scene_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int LOAD_H_START = 648,
  parameter int LOAD_H_END   = 792
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               cs_in,
  input  logic [SCENE_W-1:0] scene_in,
  output logic [SCENE_W-1:0] scene_out,
  output logic               en_load,
  output logic               commit_pulse,
  output logic [7:0]         frame_cnt,
  output logic [3:0]         missed_cnt
);

  localparam logic [9:0] C_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] C_H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] C_V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0] C_LOAD_S = 10'(LOAD_H_START);
  localparam logic [9:0] C_LOAD_E = 10'(LOAD_H_END);

  logic               w_cs_s;
  logic               w_pending;
  logic               w_bypass;
  logic               w_in_range;
  logic               w_commit_point;
  logic               w_en_load_nxt;
  logic               w_commit;
  logic               w_missed;
  commit_state_e      r_state;
  commit_state_e      w_state_nxt;
  logic [SCENE_W-1:0] r_scene_out;
  logic               r_en_load;
  logic               r_commit_pulse;
  logic [7:0]         r_frame_cnt;
  logic [3:0]         r_missed_cnt;

  // Chip select idles high, so the synchroniser resets to "not busy".
  cdc_sync2 #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_in),
    .q     (w_cs_s)
  );

  assign w_pending      = (scene_in != r_scene_out);
  assign w_bypass       = ~scene_in[EN_SCREEN];
  assign w_in_range     = (hpos < C_H_TOT) && (vpos < C_V_TOT);
  assign w_commit_point = (hpos == 10'd0) && (vpos == C_V_ACT);

  // The per-line load window is kept inside horizontal blanking.
  assign w_en_load_nxt = w_in_range &&
                         (((hpos >= C_H_ACT) && (hpos >= C_LOAD_S) && (hpos < C_LOAD_E)) ||
                          (vpos > C_V_ACT));

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_missed    = 1'b0;
    if (w_bypass) begin
      w_state_nxt = ARMED;
    end else begin
      case (r_state)
        ARMED: begin
          if (w_commit_point && w_pending) begin
            if (w_cs_s) w_commit    = 1'b1;
            else        w_state_nxt = DEFER;
          end
        end
        DEFER: begin
          if (w_cs_s) begin
            w_commit    = w_pending;
            w_state_nxt = ARMED;
          end else if (hpos == C_H_LAST) begin
            w_missed    = 1'b1;
            w_state_nxt = ARMED;
          end
        end
        default: w_state_nxt = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ARMED;
      r_scene_out    <= '0;
      r_en_load      <= 1'b0;
      r_commit_pulse <= 1'b0;
      r_frame_cnt    <= '0;
      r_missed_cnt   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_en_load      <= w_en_load_nxt;
      r_commit_pulse <= w_commit;
      if (w_bypass || w_commit) r_scene_out <= scene_in;
      if (w_commit_point) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_missed && (r_missed_cnt != 4'hF)) r_missed_cnt <= r_missed_cnt + 4'd1;
    end
  end

  assign scene_out    = r_scene_out;
  assign en_load      = r_en_load;
  assign commit_pulse = r_commit_pulse;
  assign frame_cnt    = r_frame_cnt;
  assign missed_cnt   = r_missed_cnt;

endmodule

// File: tb/tb_scene_commit_ctrl.sv
// Bench for scene_commit_ctrl: directed beam positions, a commit scoreboard
// fed by the stimulus, and a table of load-window vectors.
module tb_scene_commit_ctrl;
  import scene_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               cs_in;
  logic [SCENE_W-1:0] scene_in;
  logic [SCENE_W-1:0] scene_out;
  logic               en_load;
  logic               commit_pulse;
  logic [7:0]         frame_cnt;
  logic [3:0]         missed_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  logic [SCENE_W-1:0] exp_q[$];
  logic [SCENE_W-1:0] model_out;
  logic [7:0]         exp_frame;
  logic [3:0]         exp_missed;

  typedef struct {
    int   h;
    int   v;
    logic en;
  } load_vec_t;
  load_vec_t load_tbl[12];

  scene_commit_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hpos         (hpos),
    .vpos         (vpos),
    .cs_in        (cs_in),
    .scene_in     (scene_in),
    .scene_out    (scene_out),
    .en_load      (en_load),
    .commit_pulse (commit_pulse),
    .frame_cnt    (frame_cnt),
    .missed_cnt   (missed_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    n_errs++;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int h, input int v);
    hpos = 10'(h);
    vpos = 10'(v);
    @(posedge clk);
    if (h == 0 && v == 480) exp_frame++;
    #1;
  endtask

  task automatic settle_cs(input logic val);
    cs_in = val;
    repeat (3) drive(5, 100);
  endtask

  function automatic logic [SCENE_W-1:0] rand_scene(input logic en, input logic [SCENE_W-1:0] avoid);
    logic [SCENE_W-1:0] r;
    for (int i = 0; i < SCENE_W; i++) r[i] = 1'($urandom_range(0, 1));
    r[EN_SCREEN] = en;
    if (r == avoid) r[0] = ~r[0];
    return r;
  endfunction

  // ---------------- scoreboard: every commit strobe must be expected ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && commit_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_commit: scene_out %h with no commit expected", scene_out);
      end else begin
        chk("commit_scene", scene_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    logic [SCENE_W-1:0] p;
    logic [SCENE_W-1:0] q;
    logic [SCENE_W-1:0] b;
    logic               prev_en;

    load_tbl[0]  = '{647, 10, 1'b0};
    load_tbl[1]  = '{648, 10, 1'b1};
    load_tbl[2]  = '{791, 10, 1'b1};
    load_tbl[3]  = '{792, 10, 1'b0};
    load_tbl[4]  = '{0, 480, 1'b0};
    load_tbl[5]  = '{0, 481, 1'b1};
    load_tbl[6]  = '{799, 524, 1'b1};
    load_tbl[7]  = '{640, 10, 1'b0};
    load_tbl[8]  = '{700, 479, 1'b1};
    load_tbl[9]  = '{800, 10, 1'b0};
    load_tbl[10] = '{700, 525, 1'b0};
    load_tbl[11] = '{1023, 600, 1'b0};

    rst_n      = 1'b0;
    cs_in      = 1'b1;
    hpos       = '0;
    vpos       = '0;
    scene_in   = '0;
    exp_frame  = '0;
    exp_missed = '0;
    model_out  = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scene_out", scene_out, 0);
    chk("rst_en_load", en_load, 0);
    chk("rst_commit_pulse", commit_pulse, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_missed_cnt", missed_cnt, 0);
    rst_n = 1'b1;

    // plain commit at start of vblank
    scene_in = '1;
    drive(0, 479);
    chk("pre_commit_a", scene_out, 0);
    drive(799, 479);
    chk("pre_commit_b", scene_out, 0);
    exp_q.push_back(scene_in);
    drive(0, 480);
    chk("commit_scene_out", scene_out, scene_in);
    chk("commit_pulse_hi", commit_pulse, 1);
    chk("frame_cnt_first", frame_cnt, exp_frame);
    drive(1, 480);
    chk("commit_pulse_lo", commit_pulse, 0);
    model_out = scene_in;

    // deferred commit, chip select released mid-line
    p = rand_scene(1'b1, model_out);
    scene_in = p;
    settle_cs(1'b0);
    chk("defer_no_early", scene_out, model_out);
    drive(0, 480);
    chk("defer_hold", scene_out, model_out);
    for (int h = 1; h < 100; h++) drive(h, 480);
    chk("defer_hold_99", scene_out, model_out);
    cs_in = 1'b1;
    exp_q.push_back(p);
    drive(100, 480);
    drive(101, 480);
    chk("defer_not_yet", scene_out, model_out);
    drive(102, 480);
    chk("defer_commit", scene_out, p);
    model_out = p;
    chk("defer_missed_zero", missed_cnt, 0);
    drive(103, 480);

    // chip select busy for the whole commit line
    p = rand_scene(1'b1, model_out);
    scene_in = p;
    settle_cs(1'b0);
    drive(0, 480);
    for (int h = 1; h < 799; h++) drive(h, 480);
    chk("miss_hold", scene_out, model_out);
    chk("miss_not_yet", missed_cnt, 0);
    drive(799, 480);
    exp_missed = 4'd1;
    chk("miss_count", missed_cnt, exp_missed);
    settle_cs(1'b1);
    chk("miss_no_offpoint_commit", scene_out, model_out);
    exp_q.push_back(p);
    drive(0, 480);
    chk("miss_next_frame_commit", scene_out, p);
    chk("miss_frame_cnt", frame_cnt, exp_frame);
    model_out = p;

    // screen-off bypass follows input with one cycle latency
    b = model_out;
    b[EN_SCREEN] = 1'b0;
    b[5:0] = 6'h15;
    scene_in = b;
    chk("bypass_latency_a", scene_out, model_out);
    drive(10, 20);
    chk("bypass_bg15", scene_out, b);
    b[5:0] = 6'h2A;
    scene_in = b;
    chk("bypass_latency_b", scene_out[5:0], 6'h15);
    drive(11, 20);
    chk("bypass_bg2a", scene_out, b);
    model_out = b;
    p = b;
    p[EN_SCREEN] = 1'b1;
    scene_in = p;
    drive(100, 200);
    chk("screen_on_waits_a", scene_out, model_out);
    drive(0, 479);
    chk("screen_on_waits_b", scene_out[EN_SCREEN], 0);
    exp_q.push_back(p);
    drive(0, 480);
    chk("screen_on_commit", scene_out, p);
    model_out = p;

    // bypass entered while deferred abandons the deferral
    p = rand_scene(1'b1, model_out);
    scene_in = p;
    settle_cs(1'b0);
    drive(0, 480);
    chk("bypass_defer_hold", scene_out, model_out);
    q = rand_scene(1'b0, model_out);
    scene_in = q;
    drive(1, 480);
    chk("bypass_defer_follow", scene_out, q);
    model_out = q;
    drive(799, 480);
    chk("bypass_defer_no_miss", missed_cnt, exp_missed);

    // missed counter saturation
    scene_in = p;
    for (int i = 0; i < 17; i++) begin
      drive(0, 480);
      drive(799, 480);
      if (exp_missed != 4'hF) exp_missed++;
      chk("miss_saturate", missed_cnt, exp_missed);
    end
    chk("miss_saturate_hold", scene_out, model_out);
    settle_cs(1'b1);
    exp_q.push_back(p);
    drive(0, 480);
    chk("post_saturate_commit", scene_out, p);
    model_out = p;

    // reset while deferred
    p = rand_scene(1'b1, model_out);
    scene_in = p;
    settle_cs(1'b0);
    drive(0, 480);
    rst_n = 1'b0;
    #1;
    exp_frame  = '0;
    exp_missed = '0;
    model_out  = '0;
    chk("mid_defer_rst_frame", frame_cnt, 0);
    chk("mid_defer_rst_missed", missed_cnt, 0);
    chk("mid_defer_rst_scene", scene_out, 0);
    drive(5, 100);
    rst_n = 1'b1;
    settle_cs(1'b0);
    drive(799, 480);
    chk("mid_defer_rst_armed", missed_cnt, 0);
    cs_in = 1'b1;

    // frame counter wrap, screen off so nothing commits
    scene_in = '0;
    drive(5, 100);
    model_out = '0;
    for (int i = 0; i < 256; i++) begin
      drive(0, 480);
      drive(1, 480);
      chk("frame_wrap", frame_cnt, exp_frame);
    end

    // load window table: each value appears one cycle after its position
    drive(0, 0);
    prev_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      hpos = 10'(load_tbl[i].h);
      vpos = 10'(load_tbl[i].v);
      #1;
      chk("en_load_delay", en_load, prev_en);
      drive(load_tbl[i].h, load_tbl[i].v);
      chk("en_load_vec", en_load, load_tbl[i].en);
      prev_en = load_tbl[i].en;
    end
    chk("final_frame_cnt", frame_cnt, exp_frame);

    drive(5, 100);
    chk("commit_queue_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
